// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with valid/ready handshakes and an iterative 1-bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state;
  logic [SHAMT_W-1:0]    shamt;
  logic                  accept;
  logic [DATA_WIDTH-1:0] res;
  assign shamt    = SrcB[SHAMT_W-1:0];
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  // Iterative builds return SrcA for shift ops here; that path is only taken for amount 0.
  always_comb begin
    res = '0;
    case (Operation)
      4'b0000: res = SrcA & SrcB;
      4'b0001: res = SrcA | SrcB;
      4'b0010: res = SrcA + SrcB;
      4'b0100: res = SrcA ^ SrcB;
      4'b0101: res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      4'b0110: res = SrcA - SrcB;
      4'b0111: res = DATA_WIDTH'(SrcA < SrcB);
      4'b1010: res = DATA_WIDTH'(SrcA != SrcB);
      4'b1011: res = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
      4'b1100: res = DATA_WIDTH'(SrcA >= SrcB);
      4'b1101: res = SrcB;
      4'b1110: res = DATA_WIDTH'(SrcA == SrcB);
`ifdef ALU_FAST_SHIFT_EN
      4'b0011: res = SrcA << shamt;
      4'b1000: res = SrcA >> shamt;
      4'b1001: res = DATA_WIDTH'($signed(SrcA) >>> shamt);
`else
      4'b0011, 4'b1000, 4'b1001: res = SrcA;
`endif
      default: res = '0;
    endcase
  end
`ifdef ALU_FAST_SHIFT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else if (accept) begin
      ALUResult <= res;
      Zero      <= res == '0;
      state     <= DONE;
      out_valid <= 1'b1;
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
`else
  logic [DATA_WIDTH-1:0] acc, acc_nxt;
  logic [SHAMT_W-1:0]    cnt;
  logic [3:0]            op_q;
  logic                  is_shift;
  assign is_shift = Operation == 4'b0011 || Operation == 4'b1000 || Operation == 4'b1001;
  assign acc_nxt  = op_q == 4'b0011 ? acc << 1 :
                    op_q == 4'b1001 ? {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]} : acc >> 1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= '0;
    end else if (accept) begin
      if (is_shift && shamt != '0) begin
        acc       <= SrcA;
        cnt       <= shamt;
        op_q      <= Operation;
        state     <= SHIFT;
        out_valid <= 1'b0;
      end else begin
        ALUResult <= res;
        Zero      <= res == '0;
        state     <= DONE;
        out_valid <= 1'b1;
      end
    end else if (state == SHIFT) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == SHAMT_W'(1)) begin
        ALUResult <= acc_nxt;
        Zero      <= acc_nxt == '0;
        state     <= DONE;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: scoreboard bench for alu_seq_exec; driver pushes model results, monitor pops on handshake.
module tb_alu_seq_exec;
  logic        clk = 0, reset_n = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, Zero;
  logic [3:0]  Operation = 0;
  logic [31:0] SrcA = 0, SrcB = 0, ALUResult;
  typedef struct {logic [31:0] res; int lat; int acyc;} exp_t;
  exp_t q[$];
  int   n_tests = 0, n_fail = 0, cyc = 0, rmode = 0;
  logic mon_en = 0;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh = int'(b[4:0]);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a << sh;
      4'd4:  return a ^ b;
      4'd5:  return 32'($signed(a) < $signed(b));
      4'd6:  return a - b;
      4'd7:  return 32'(a < b);
      4'd8:  return a >> sh;
      4'd9:  return 32'($signed(a) >>> sh);
      4'd10: return 32'(a != b);
      4'd11: return 32'($signed(a) >= $signed(b));
      4'd12: return 32'(a >= b);
      4'd13: return b;
      4'd14: return 32'(a == b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (op == 4'd3 || op == 4'd8 || op == 4'd9) ? int'(b[4:0]) + 1 : 1;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    exp_t e;
    in_valid = 1; Operation = op; SrcA = a; SrcB = b;
    #2;
    while (!in_ready && t < 200) begin @(negedge clk); #2; t++; end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 required 1 after %0d cycles", t);
    end else begin
      e.res = model(op, a, b); e.lat = exp_lat(op, b); e.acyc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 0; SrcA = $urandom; SrcB = $urandom; Operation = 4'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 3000) begin @(negedge clk); t++; end
    chk("drain_empty", 32'(q.size()), 0);
    q.delete();
    @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk); #1;
    out_ready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : ($urandom % 4 != 0);
  end

  initial begin : monitor
    logic        seen = 0, held = 0, prev_z = 0;
    logic [31:0] prev_res = 0;
    exp_t        e;
    forever begin
      @(negedge clk); #3;
      if (!mon_en) begin
        seen = 0; held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(out_valid), 1);
          if (out_valid) begin
            chk("hold_result", ALUResult, prev_res);
            chk("hold_zero", 32'(Zero), 32'(prev_z));
          end
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_output: out_valid got 1 required 0, result 0x%08h", ALUResult);
          end else begin
            if (!seen) chk("latency", 32'(cyc - q[0].acyc), 32'(q[0].lat));
            seen = 1;
            if (!out_ready) chk("in_ready_stall", 32'(in_ready), 0);
            else begin
              e = q.pop_front();
              chk("result", ALUResult, e.res);
              chk("zero", 32'(Zero), 32'(e.res == 0));
              seen = 0;
            end
          end
        end else if (q.size() > 0 && q[0].acyc < cyc) chk("in_ready_shift", 32'(in_ready), 0);
        held = out_valid && !out_ready; prev_res = ALUResult; prev_z = Zero;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_zero", 32'(Zero), 1);
    reset_n = 1;
    @(negedge clk); #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    mon_en = 1;
    @(negedge clk);
    issue(4'd2, 32'h7FFFFFFF, 32'd1);
    issue(4'd6, 32'd5, 32'd5);
    issue(4'd9, 32'h80000000, 32'd4);
    issue(4'd3, 32'hABCD1234, 32'h20);
    issue(4'd11, 32'hFFFFFFFF, 32'd1);
    issue(4'd12, 32'hFFFFFFFF, 32'd1);
    issue(4'd14, 32'd3, 32'd3);
    issue(4'd10, 32'd3, 32'd3);
    issue(4'd5, 32'hFFFFFFFE, 32'd1);
    issue(4'd7, 32'hFFFFFFFE, 32'd1);
    issue(4'd15, 32'h12345678, 32'h9ABCDEF0);
    issue(4'd8, 32'hF0000000, 32'd31);
    issue(4'd13, 32'h5A5A5A5A, 32'hDEADBEEF);
    issue(4'd0, 32'hFF00FF00, 32'h0FF00FF0);
    issue(4'd1, 32'hFF00FF00, 32'h0FF00FF0);
    issue(4'd4, 32'hFFFF0000, 32'hFFFF0000);
    drain();
    // Backpressure, then a new op accepted on the same edge the held result is taken.
    rmode = 2;
    issue(4'd2, 32'd10, 32'd20);
    repeat (3) @(negedge clk);
    rmode = 0;
    issue(4'd2, 32'd1, 32'hFFFFFFFF);
    issue(4'd6, 32'd0, 32'd1);
    issue(4'd1, 32'd0, 32'd0);
    drain();
    // Reset while an SRL by 20 is in flight (or held, in barrel builds).
    mon_en = 0; rmode = 2;
    in_valid = 1; Operation = 4'd8; SrcA = 32'hFFFFFFFF; SrcB = 32'd20;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_result", ALUResult, 0);
    chk("midrst_zero", 32'(Zero), 1);
    @(negedge clk);
    reset_n = 1; rmode = 0;
    @(negedge clk); #2;
    chk("postrst_in_ready", 32'(in_ready), 1);
    chk("postrst_out_valid", 32'(out_valid), 0);
    chk("postrst_result", ALUResult, 0);
    mon_en = 1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("postrst_no_stale", 32'(out_valid), 0);
    @(negedge clk);
    // Randomized traffic with random consumer stalls and idle gaps.
    rmode = 1;
    repeat (300) begin
      logic [31:0] a, b;
      a = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
      b = ($urandom % 6 == 0) ? a : $urandom;
      issue(4'($urandom_range(0, 15)), a, b);
      if ($urandom % 5 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rmode = 0;
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
